// File: rtl/multicycle_mips_core.sv
// Multi-cycle MIPS subset core: one shared ALU and one unified req/ready memory port,
// sequenced by a control FSM through IR/MDR/A/B/ALUOut holding registers.
module multicycle_mips_core #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          REG_COUNT  = 32,
    parameter int          REG_ADDR_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc,
    output logic        halted,
    output logic        illegal_instr,
    output logic        instr_retired
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d;
    logic [31:0] a_q, a_d, b_q, b_d, alu_q, alu_d;
    logic        illegal_q, illegal_d, retired_q, retired_d;
    logic        port_req;

    logic [31:0]           gpr_q [REG_COUNT];
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_waddr;
    logic [31:0]           rf_wdata;

    logic [5:0]            opcode, funct;
    logic [REG_ADDR_W-1:0] rs, rt, rd;
    logic [31:0]           simm, rs_val, rt_val;

    assign opcode = ir_q[31:26];
    assign funct  = ir_q[5:0];
    assign rs     = ir_q[21 +: REG_ADDR_W];
    assign rt     = ir_q[16 +: REG_ADDR_W];
    assign rd     = ir_q[11 +: REG_ADDR_W];
    assign simm   = {{16{ir_q[15]}}, ir_q[15:0]};
    assign rs_val = (rs == '0) ? '0 : gpr_q[rs];
    assign rt_val = (rt == '0) ? '0 : gpr_q[rt];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        mdr_d     = mdr_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_d     = alu_q;
        illegal_d = illegal_q;
        retired_d = 1'b0;
        rf_we     = 1'b0;
        rf_waddr  = rt;
        rf_wdata  = mdr_q;
        port_req  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc_q;
        mem_wdata = b_q;
        case (state_q)
            S_FETCH: begin
                port_req = 1'b1;
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + 32'd4;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d   = rs_val;
                b_d   = rt_val;
                alu_d = pc_q + (simm << 2);
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_d   = a_q + simm;
                state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                port_req = 1'b1;
                mem_addr = alu_q;
                if (mem_ready) begin
                    mdr_d   = mem_rdata;
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                rf_we     = 1'b1;
                retired_d = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWR: begin
                port_req = 1'b1;
                mem_we   = 1'b1;
                mem_addr = alu_q;
                if (mem_ready) begin
                    retired_d = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_EXEC: begin
                state_d = S_ALUWB;
                case (funct)
                    6'h20: alu_d = a_q + b_q;
                    6'h22: alu_d = a_q - b_q;
                    6'h24: alu_d = a_q & b_q;
                    6'h25: alu_d = a_q | b_q;
                    6'h2A: alu_d = ($signed(a_q) < $signed(b_q)) ? 32'd1 : 32'd0;
                    default: begin
                        // An unknown funct is still an undecodable instruction.
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_ALUWB: begin
                rf_we     = 1'b1;
                rf_waddr  = rd;
                rf_wdata  = alu_q;
                retired_d = 1'b1;
                state_d   = S_FETCH;
            end
            S_ADDIEX: begin
                alu_d   = a_q + simm;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                rf_we     = 1'b1;
                rf_wdata  = alu_q;
                retired_d = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                if (a_q == b_q) pc_d = alu_q;
                retired_d = 1'b1;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_d      = {pc_q[31:28], ir_q[25:0], 2'b00};
                retired_d = 1'b1;
                state_d   = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            mdr_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_q     <= '0;
            illegal_q <= 1'b0;
            retired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mdr_q     <= mdr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_q     <= alu_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < REG_COUNT; i++) gpr_q[i] <= '0;
        end else if (rf_we && (rf_waddr != '0)) begin
            gpr_q[rf_waddr] <= rf_wdata;
        end
    end

    // Request is masked during reset so an abandoned access disappears immediately.
    assign mem_req       = port_req & rst;
    assign pc            = pc_q;
    assign halted        = (state_q == S_HALT);
    assign illegal_instr = illegal_q;
    assign instr_retired = retired_q;
endmodule

// File: tb/tb_multicycle_mips_core.sv
// Bench for multicycle_mips_core: ISA-level reference model stepped on each retire,
// with cycle-count, store and handshake checks under several memory wait patterns.
module tb_multicycle_mips_core;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
    logic        halted, illegal_instr, instr_retired;

    logic [31:0] mem   [256];
    logic [31:0] m_mem [256];
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    int          errors = 0;
    int          checks = 0;

    int          n_ret, n_st;
    logic [31:0] r_oldpc [128];
    logic [31:0] r_newpc [128];
    int          r_cyc [128];
    logic [31:0] halt_pc, first_st_addr, first_st_data;

    always #5 clk = ~clk;
    assign mem_rdata = mem[mem_addr[9:2]];

    multicycle_mips_core #(.RESET_PC(32'h0), .REG_COUNT(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc),
        .halted(halted), .illegal_instr(illegal_instr), .instr_retired(instr_retired)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_j(input int t);
        return {6'h02, 26'(t)};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'hFC00_0000;
        for (int i = 128; i < 256; i++) mem[i] = $urandom;
    endtask

    task automatic reset_model();
        m_pc = 32'h0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
    endtask

    task automatic sync_model();
        for (int i = 0; i < 256; i++) m_mem[i] = mem[i];
        reset_model();
    endtask

    // Executes the instruction at m_pc architecturally; illegal leaves state untouched.
    task automatic model_step(output int base, output logic is_st, output logic [31:0] sa,
                              output logic [31:0] sd, output logic ill);
        logic [31:0] ins, a, b, simm, npc, ea, res;
        logic [5:0]  op, fn;
        int          rs, rt, rd;
        ins  = m_mem[m_pc[9:2]];
        op   = ins[31:26];
        fn   = ins[5:0];
        rs   = int'(ins[25:21]);
        rt   = int'(ins[20:16]);
        rd   = int'(ins[15:11]);
        a    = m_regs[rs];
        b    = m_regs[rt];
        simm = {{16{ins[15]}}, ins[15:0]};
        npc  = m_pc + 32'd4;
        ea   = a + simm;
        res  = '0;
        base = 0; is_st = 1'b0; sa = '0; sd = '0; ill = 1'b0;
        case (op)
            6'h00: begin
                base = 4;
                case (fn)
                    6'h20: res = a + b;
                    6'h22: res = a - b;
                    6'h24: res = a & b;
                    6'h25: res = a | b;
                    6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: ill = 1'b1;
                endcase
                if (!ill && rd != 0) m_regs[rd] = res;
            end
            6'h08: begin base = 4; if (rt != 0) m_regs[rt] = ea; end
            6'h23: begin base = 5; if (rt != 0) m_regs[rt] = m_mem[ea[9:2]]; end
            6'h2B: begin base = 4; is_st = 1'b1; sa = ea; sd = b; m_mem[ea[9:2]] = b; end
            6'h04: begin base = 3; if (a == b) npc = npc + (simm << 2); end
            6'h02: begin base = 3; npc = {npc[31:28], ins[25:0], 2'b00}; end
            default: ill = 1'b1;
        endcase
        if (!ill) m_pc = npc;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_illegal", 32'(illegal_instr), 32'd0);
        chk("rst_retired", 32'(instr_retired), 32'd0);
        chk("rst_pc", pc, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    // mode 0: zero wait; 1: three waits per access; 2: random 40% waits.
    task automatic run(input int mode, input int max_ret, input int max_cyc);
        int          cyc, waits, st_cnt, wcnt, base;
        logic        pend, done, is_st, ill, p_we;
        logic [31:0] p_addr, p_wdata, st_addr, st_data, sa, sd, oldpc;
        cyc = 0; waits = 0; st_cnt = 0; wcnt = 0; pend = 1'b0; done = 1'b0;
        p_we = 1'b0; p_addr = '0; p_wdata = '0; st_addr = '0; st_data = '0;
        n_ret = 0; n_st = 0; halt_pc = '1; first_st_addr = '1; first_st_data = '1;
        for (int k = 0; k < max_cyc && !done; k++) begin
            if (pend) begin
                chk("hold_req", 32'(mem_req), 32'd1);
                chk("hold_addr", mem_addr, p_addr);
                chk("hold_we", 32'(mem_we), 32'(p_we));
                chk("hold_wdata", mem_wdata, p_wdata);
            end
            if (instr_retired) begin
                oldpc = m_pc;
                model_step(base, is_st, sa, sd, ill);
                chk("retire_legal", 32'(ill), 32'd0);
                chk("retire_pc", pc, m_pc);
                chk("retire_cycles", 32'(cyc), 32'(base + waits));
                chk("store_count", 32'(st_cnt), 32'(is_st));
                if (is_st && st_cnt == 1) begin
                    chk("store_addr", st_addr, sa);
                    chk("store_data", st_data, sd);
                end
                if (n_ret < 128) begin
                    r_oldpc[n_ret] = oldpc;
                    r_newpc[n_ret] = pc;
                    r_cyc[n_ret]   = cyc;
                end
                n_ret++;
                cyc = 0; waits = 0; st_cnt = 0;
                if (max_ret > 0 && n_ret >= max_ret) done = 1'b1;
            end
            if (!done && halted) begin
                halt_pc = pc;
                model_step(base, is_st, sa, sd, ill);
                chk("halt_on_illegal", 32'(ill), 32'd1);
                chk("halt_pc", pc, m_pc + 32'd4);
                chk("halt_illegal_flag", 32'(illegal_instr), 32'd1);
                for (int h = 0; h < 20; h++) begin
                    mem_ready = 1'($urandom_range(1));
                    @(negedge clk);
                    #1;
                    chk("halt_no_req", 32'(mem_req), 32'd0);
                end
                done = 1'b1;
            end else if (!done) begin
                chk("illegal_low", 32'(illegal_instr), 32'd0);
            end
            if (!done) begin
                if (mem_req) begin
                    if (!pend) wcnt = 0;
                    case (mode)
                        0:       mem_ready = 1'b1;
                        1:       mem_ready = (wcnt >= 3);
                        default: mem_ready = ($urandom_range(99) >= 40);
                    endcase
                    if (!mem_ready) begin
                        waits++; wcnt++; pend = 1'b1;
                        p_addr = mem_addr; p_we = mem_we; p_wdata = mem_wdata;
                    end else begin
                        pend = 1'b0;
                        if (mem_we) begin
                            mem[mem_addr[9:2]] = mem_wdata;
                            st_cnt++;
                            st_addr = mem_addr;
                            st_data = mem_wdata;
                            if (n_st == 0) begin
                                first_st_addr = mem_addr;
                                first_st_data = mem_wdata;
                            end
                            n_st++;
                        end
                    end
                end else begin
                    pend = 1'b0;
                    mem_ready = 1'($urandom_range(1));
                end
                cyc++;
                @(negedge clk);
                #1;
            end
        end
        chk("run_finished", 32'(done), 32'd1);
    endtask

    function automatic int cyc_at(input logic [31:0] opc);
        for (int i = 0; i < n_ret && i < 128; i++)
            if (r_oldpc[i] == opc) return r_cyc[i];
        return -1;
    endfunction

    function automatic logic [31:0] newpc_at(input logic [31:0] opc);
        for (int i = 0; i < n_ret && i < 128; i++)
            if (r_oldpc[i] == opc) return r_newpc[i];
        return '1;
    endfunction

    task automatic load_p1();
        clear_mem();
        mem[0]  = enc_i(8, 0, 1, 5);
        mem[1]  = enc_i(8, 0, 2, -3);
        mem[2]  = enc_r(1, 2, 3, 32'h20);
        mem[3]  = enc_i(32'h2B, 0, 3, 8);
        mem[4]  = enc_i(32'h23, 0, 4, 8);
        mem[5]  = enc_i(32'h2B, 0, 4, 32'h200);
        mem[6]  = enc_i(8, 0, 6, -1);
        mem[7]  = enc_i(8, 0, 7, 1);
        mem[8]  = enc_r(6, 7, 5, 32'h2A);
        mem[9]  = enc_i(32'h2B, 0, 5, 32'h204);
        mem[10] = enc_i(8, 0, 0, 7);
        mem[11] = enc_i(32'h2B, 0, 0, 32'h208);
        mem[12] = enc_i(4, 1, 2, 5);
        mem[13] = enc_r(1, 2, 5, 32'h22);
        mem[14] = enc_i(32'h2B, 0, 5, 32'h20C);
        sync_model();
    endtask

    task automatic gen_random();
        int fns [5];
        int kind, r1, r2, r3, lim;
        fns = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2A};
        clear_mem();
        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(8));
            r1   = int'($urandom_range(7));
            r2   = int'($urandom_range(7));
            r3   = int'($urandom_range(7));
            lim  = (39 - i < 3) ? 39 - i : 3;
            case (kind)
                3, 4: mem[i] = enc_r(r1, r2, r3, fns[$urandom_range(4)]);
                5:    mem[i] = enc_i(32'h23, 0, r2, 512 + 4 * int'($urandom_range(127)));
                6:    mem[i] = enc_i(32'h2B, 0, r2, 512 + 4 * int'($urandom_range(127)));
                7:    mem[i] = enc_i(4, r1, ($urandom_range(1) == 1) ? r1 : r2, int'($urandom_range(lim)));
                8:    mem[i] = enc_j(i + 1 + int'($urandom_range(lim)));
                default: mem[i] = enc_i(8, r1, r2, int'($urandom_range(65535)));
            endcase
        end
        for (int k = 0; k < 8; k++) mem[40 + k] = enc_i(32'h2B, 0, k, 32'h300 + 4 * k);
        mem[48] = ($urandom_range(1) == 1) ? 32'h0400_0000 : 32'h4000_0000;
        sync_model();
    endtask

    initial begin
        // Arithmetic, store/load, slt, r0 write, untaken beq at zero wait.
        load_p1();
        do_reset();
        run(0, 0, 2000);
        chk("lit_first3_cycles", 32'(r_cyc[0] + r_cyc[1] + r_cyc[2]), 32'd12);
        chk("lit_add_result", mem[128], 32'd2);
        chk("lit_slt_result", mem[129], 32'd1);
        chk("lit_r0_zero", mem[130], 32'd0);
        chk("lit_sub_result", mem[131], 32'd8);
        chk("lit_beq_untaken", newpc_at(32'h30), 32'h34);
        chk("lit_p1_halt_pc", halt_pc, 32'h40);

        // Same program with three wait cycles on every access.
        load_p1();
        do_reset();
        run(1, 0, 2000);
        chk("lit_sw_addr", first_st_addr, 32'h8);
        chk("lit_sw_data", first_st_data, 32'h2);
        chk("lit_sw_cycles", 32'(cyc_at(32'h0C)), 32'd10);
        chk("lit_lw_cycles", 32'(cyc_at(32'h10)), 32'd11);
        chk("lit_lw_value", mem[128], 32'd2);

        // Taken beq back onto itself.
        clear_mem();
        mem[0] = enc_i(8, 0, 1, 1);
        for (int i = 1; i < 4; i++) mem[i] = enc_r(0, 0, 0, 32'h20);
        mem[4] = enc_i(4, 1, 1, -1);
        sync_model();
        do_reset();
        run(2, 10, 2000);
        chk("lit_beq_loop_a", r_newpc[4], 32'h10);
        chk("lit_beq_loop_b", r_newpc[9], 32'h10);

        // Jump, then reset in the middle of a stalled fetch.
        clear_mem();
        mem[0] = enc_j(32'h40);
        sync_model();
        do_reset();
        run(0, 1, 200);
        chk("lit_j_pc", pc, 32'h100);
        mem_ready = 1'b0;
        chk("lit_j_fetch_req", 32'(mem_req), 32'd1);
        chk("lit_j_fetch_addr", mem_addr, 32'h100);
        @(negedge clk);
        #1;
        chk("stall_fetch_addr", mem_addr, 32'h100);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst_mem_req", 32'(mem_req), 32'd0);
        chk("midrst_pc", pc, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        reset_model();
        #1;
        chk("restart_req", 32'(mem_req), 32'd1);
        chk("restart_addr", mem_addr, 32'h0);
        run(2, 0, 500);
        chk("lit_j_halt_pc", halt_pc, 32'h104);

        // Illegal opcode, then illegal R-type funct, both at 0x8.
        for (int t = 0; t < 2; t++) begin
            clear_mem();
            mem[0] = enc_i(8, 0, 1, 1);
            mem[1] = enc_i(8, 0, 2, 2);
            mem[2] = (t == 0) ? 32'hFC00_0000 : enc_r(1, 2, 3, 32'h3F);
            sync_model();
            do_reset();
            run(t, 0, 500);
            chk("lit_illegal_halt_pc", halt_pc, 32'hC);
            chk("lit_illegal_flag", 32'(illegal_instr), 32'd1);
            chk("lit_halted", 32'(halted), 32'd1);
        end

        // Random programs under each wait pattern.
        for (int p = 0; p < 6; p++) begin
            gen_random();
            do_reset();
            run(p % 3, 0, 4000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
